// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 word mux.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Select/source field width; at least one bit so a 2-input mux still has a select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr, modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [2*N-1:0] w_req_dbl;
    logic [SEL_W:0] w_base;
    logic [N-1:0]   w_req_rot;

    // Doubling the request vector turns the wrap-around search into a plain window.
    assign w_req_dbl = {req, req};
    assign w_base    = {1'b0, ptr};
    assign w_req_rot = w_req_dbl[w_base +: N];

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!grant_valid && w_req_rot[i]) begin
                grant_valid = 1'b1;
                grant       = SEL_W'((int'(ptr) + i) % int'(N));
            end
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-input registered word mux with select or round-robin choice, valid/ready and flush.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int unsigned  WIDTH  = 32,
    parameter int unsigned  NUM_IN = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_src;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_rr_grant;
    logic             w_rr_valid;
    logic             w_sel_hit;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic             w_load_en;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SEL_W-1:0] w_ptr_nxt;

    rr_arbiter #(
        .N     (NUM_IN),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (r_ptr),
        .grant       (w_rr_grant),
        .grant_valid (w_rr_valid)
    );

    // An out-of-range sel matches no channel, so it never grants.
    always_comb begin
        w_sel_hit = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_sel_hit = 1'b1;
            end
        end
    end

    assign w_grant       = (mode == MODE_RR) ? w_rr_grant : sel;
    assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_sel_hit;
    assign w_load_en     = !r_valid || out_ready;
    assign w_xfer        = w_load_en && w_grant_valid && !flush && !Rst;
    assign w_ptr_nxt     = (w_grant == SEL_W'(NUM_IN - 1)) ? '0 : w_grant + SEL_W'(1);

    always_comb begin
        in_ready = '0;
        w_data   = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (w_grant == SEL_W'(i)) begin
                in_ready[i] = w_xfer;
                w_data      = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_data  <= '0;
            r_src   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load_en) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_data;
                r_src  <= w_grant;
                if (mode == MODE_RR) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Randomised scoreboard bench for mux_nto1_pipe, plus a 3-input instance for out-of-range select.
module tb_mux_nto1_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         mode;
    logic         flush;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    logic         rst3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [1:0]   sel3;
    logic         mode3;
    logic         flush3;
    logic [31:0]  out_data3;
    logic [1:0]   out_src3;
    logic         out_valid3;
    logic         out_ready3;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   src_log[$];
    bit   m_valid;
    int   m_ptr;

    always #5 clk = ~clk;

    mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut (
        .Clk       (clk),
        .Rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .flush     (flush),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .Clk       (clk),
        .Rst       (rst3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .mode      (mode3),
        .flush     (flush3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the handshake rules for the current inputs, then advances.
    task automatic model_eval();
        int         g;
        bit         gv;
        bit         le;
        logic [3:0] er;
        le = !m_valid || out_ready;
        gv = 0;
        g  = 0;
        if (mode == 1'b0) begin
            g  = int'(sel);
            gv = in_valid[g];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!gv && in_valid[(m_ptr + k) % 4]) begin
                    gv = 1;
                    g  = (m_ptr + k) % 4;
                end
            end
        end
        er = (!rst && !flush && le && gv) ? 4'(1 << g) : 4'b0;
        check("in_ready", {60'd0, in_ready}, {60'd0, er});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (rst) begin
            m_valid = 0;
            m_ptr   = 0;
            exp_q.delete();
        end else if (flush) begin
            if (m_valid) void'(exp_q.pop_back());
            m_valid = 0;
        end else if (le) begin
            m_valid = (er != 4'b0);
            if (m_valid) begin
                exp_q.push_back('{d: in_data[g*32 +: 32], s: 2'(g)});
                if (mode == 1'b1) m_ptr = (g + 1) % 4;
            end
        end
    endtask

    task automatic step(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic f, input logic ordy, input logic [31:0] d2);
        @(posedge clk);
        #1;
        rst       = r;
        mode      = m;
        sel       = s;
        in_valid  = v;
        flush     = f;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
        in_data[64 +: 32] = d2;
        #2;
        model_eval();
    endtask

    // Monitor: every word the DUT hands downstream must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data %0h src %0d expected none", out_data,
                         out_src);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                src_log.push_back(int'(out_src));
                if (out_data !== e.d || out_src !== e.s) begin
                    errors++;
                    $display("FAIL out_word: got data %0h src %0d expected data %0h src %0d",
                             out_data, out_src, e.d, e.s);
                end
            end
        end
    end

    initial begin
        int exp_log[7] = '{0, 1, 2, 3, 0, 3, 0};
        rst = 1; mode = 0; sel = 0; in_valid = 0; flush = 0; out_ready = 0; in_data = '0;
        rst3 = 1; mode3 = 0; sel3 = 0; in_valid3 = 0; flush3 = 0; out_ready3 = 0;
        in_data3 = '0;
        m_valid = 0;
        m_ptr   = 0;

        step(1, 0, 0, 4'b0000, 0, 0, 0);
        step(1, 0, 0, 4'b0000, 0, 0, 0);
        step(0, 0, 0, 4'b0000, 0, 0, 0);
        check("reset_out_data", {32'd0, out_data}, 64'd0);
        check("reset_out_src", {62'd0, out_src}, 64'd0);

        // Select mode, then stall with the selected channel still valid.
        step(0, 0, 2, 4'b0100, 0, 1, 32'hDEADBEEF);
        check("sel_in_ready", {60'd0, in_ready}, 64'h4);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2, 4'b0100, 0, 0, $urandom);
            check("stall_in_ready", {60'd0, in_ready}, 64'h0);
            check("stall_out_data", {32'd0, out_data}, 64'hDEADBEEF);
            check("stall_out_src", {62'd0, out_src}, 64'd2);
        end
        step(0, 0, 2, 4'b0100, 0, 1, 32'h12345678);
        check("release_in_ready", {60'd0, in_ready}, 64'h4);
        step(0, 0, 0, 4'b0000, 0, 1, 0);
        check("release_out_data", {32'd0, out_data}, 64'h12345678);
        #3;
        src_log.delete();

        // Round-robin rotation, then a sparse request pattern from ptr=1.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 4'b1111, 0, 1, $urandom);
        step(0, 1, 0, 4'b1001, 0, 1, $urandom);
        step(0, 1, 0, 4'b1001, 0, 1, $urandom);
        step(0, 1, 0, 4'b0000, 0, 1, 0);
        #3;
        check("rr_log_len", 64'(src_log.size()), 64'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < src_log.size()) check("rr_src_seq", 64'(src_log[i]), 64'(exp_log[i]));
        end

        // Flush with a word registered and a valid request present; ptr must not move.
        step(0, 1, 0, 4'b1111, 0, 1, $urandom);
        step(0, 1, 0, 4'b1111, 1, 1, $urandom);
        check("flush_in_ready", {60'd0, in_ready}, 64'h0);
        step(0, 1, 0, 4'b1111, 0, 1, $urandom);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_ptr_held", {60'd0, in_ready}, 64'h4);

        // Reset while holding a word.
        step(0, 1, 0, 4'b1111, 0, 0, $urandom);
        step(1, 1, 0, 4'b1111, 0, 0, $urandom);
        check("rst_in_ready", {60'd0, in_ready}, 64'h0);
        step(0, 1, 0, 4'b1111, 0, 0, $urandom);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_src", {62'd0, out_src}, 64'd0);
        check("rst_ptr", {60'd0, in_ready}, 64'h1);

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(63) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
                 ($urandom_range(7) == 0), ($urandom_range(3) != 0), $urandom);
        end
        step(0, 0, 0, 4'b0000, 0, 1, 0);
        step(0, 0, 0, 4'b0000, 0, 1, 0);

        // Three-input instance: sel=3 is out of range and must never grant.
        @(posedge clk); #1;
        rst3 = 0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1;
        in_data3 = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        for (int i = 0; i < 3; i++) begin
            #2;
            check("n3_oor_in_ready", {61'd0, in_ready3}, 64'h0);
            check("n3_oor_out_valid", {63'd0, out_valid3}, 64'd0);
            @(posedge clk); #1;
        end
        sel3 = 2'd2;
        #2;
        check("n3_sel2_in_ready", {61'd0, in_ready3}, 64'h4);
        @(posedge clk); #1;
        in_valid3 = 3'b000;
        #2;
        check("n3_out_valid", {63'd0, out_valid3}, 64'd1);
        check("n3_out_src", {62'd0, out_src3}, 64'd2);
        check("n3_out_data", {32'd0, out_data3}, 64'hCAFE0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
